// File: rtl/fifo_pkg.sv
// ============================================================================
// Module : fifo_pkg
// Brief  : Shared defaults and the level-width helper for the FIFO slice.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package fifo_pkg;

  localparam int DEF_DATA_BITS = 8;
  localparam int DEF_ADDR_BITS = 3;

  // Occupancy must represent 0..DEPTH, so one bit wider than the pointers.
  function automatic int level_width(input int addr_bits);
    return addr_bits + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_ram.sv
// ============================================================================
// Module : fifo_ram
// Brief  : DEPTH x DATA_BITS storage, synchronous write, asynchronous read.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fifo_ram
  import fifo_pkg::*;
#(
  parameter int DATA_BITS = DEF_DATA_BITS,
  parameter int ADDR_BITS = DEF_ADDR_BITS
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [DATA_BITS-1:0] wdata,
  input  logic [ADDR_BITS-1:0] raddr,
  output logic [DATA_BITS-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_BITS;

  // Contents are intentionally never reset.
  logic [DATA_BITS-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

`default_nettype wire

// File: rtl/fifo_level.sv
// ============================================================================
// Module : fifo_level
// Brief  : Show-ahead FIFO with occupancy level and status flags.
//          Optional sticky overflow/underflow outputs under FIFO_ERR_FLAGS_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fifo_level
  import fifo_pkg::*;
#(
  parameter int DATA_BITS = DEF_DATA_BITS,
  parameter int ADDR_BITS = DEF_ADDR_BITS,
  parameter int AF_THRESH = (1 << ADDR_BITS) - 1,
  parameter int AE_THRESH = 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              flush,
  input  logic                              rd_en,
  input  logic                              wr_en,
  input  logic [DATA_BITS-1:0]              wr_data,
  output logic [DATA_BITS-1:0]              rd_data,
  output logic [level_width(ADDR_BITS)-1:0] level,
  output logic                              full,
  output logic                              empty,
  output logic                              almost_full,
  output logic                              almost_empty
`ifdef FIFO_ERR_FLAGS_EN
  ,
  output logic                              overflow,
  output logic                              underflow
`endif
);

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam int LVL_W = level_width(ADDR_BITS);

  localparam logic [LVL_W-1:0] DEPTH_LVL = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] AF_LVL    = LVL_W'(AF_THRESH);
  localparam logic [LVL_W-1:0] AE_LVL    = LVL_W'(AE_THRESH);
  localparam logic [LVL_W-1:0] LVL_ONE   = LVL_W'(1);
  localparam logic [ADDR_BITS-1:0] PTR_ONE = ADDR_BITS'(1);

  generate
    if (AF_THRESH > DEPTH || AE_THRESH > DEPTH || AF_THRESH < 0 || AE_THRESH < 0)
    begin : g_bad_thresh
      $error("fifo_level: AF_THRESH/AE_THRESH must lie within 0..DEPTH");
    end
  endgenerate

  logic [ADDR_BITS-1:0] wr_ptr;
  logic [ADDR_BITS-1:0] rd_ptr;
  logic                 wr_accept;
  logic                 rd_accept;
  logic                 ram_we;
  logic [LVL_W-1:0]     level_next;

  // A write into a full FIFO is still taken when a read frees the slot.
  assign wr_accept = wr_en && ((level != DEPTH_LVL) || rd_en);
  assign rd_accept = rd_en && (level != '0);
  assign ram_we    = wr_accept && !flush && !reset;

  always_comb begin
    level_next = level;
    if (wr_accept && !rd_accept) begin
      level_next = level + LVL_ONE;
    end else if (rd_accept && !wr_accept) begin
      level_next = level - LVL_ONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_accept) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (rd_accept) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      level <= level_next;
    end
  end

  // Flags decode only the registered level, so they trail the accepting edge.
  assign full         = (level == DEPTH_LVL);
  assign empty        = (level == '0);
  assign almost_full  = (level >= AF_LVL);
  assign almost_empty = (level <= AE_LVL);

`ifdef FIFO_ERR_FLAGS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en && !wr_accept) begin
        overflow <= 1'b1;
      end
      if (rd_en && (level == '0)) begin
        underflow <= 1'b1;
      end
    end
  end
`endif

  fifo_ram #(
    .DATA_BITS (DATA_BITS),
    .ADDR_BITS (ADDR_BITS)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wr_ptr),
    .wdata (wr_data),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

endmodule

`default_nettype wire

// File: doc/fifo_level.md
FIFO_LEVEL -- requirements
Module: fifo_level

Interface
REQ-001 The block SHALL have parameter DATA_BITS, default 8, meaning entry width in bits.
REQ-002 The block SHALL have parameter ADDR_BITS, default 3, meaning log2 of depth (DEPTH = 2**ADDR_BITS).
REQ-003 The block SHALL have parameter AF_THRESH, default DEPTH-1, meaning the almost_full assertion level.
REQ-004 The block SHALL have parameter AE_THRESH, default 1, meaning the almost_empty assertion level.
REQ-005 The block SHALL have port clk, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 The block SHALL have port flush, input, 1 bit: synchronous clear of contents.
REQ-008 The block SHALL have port rd_en, input, 1 bit: pop the front entry.
REQ-009 The block SHALL have port wr_en, input, 1 bit: push wr_data.
REQ-010 The block SHALL have port wr_data, input, DATA_BITS: the data to push.
REQ-011 The block SHALL have port rd_data, output, DATA_BITS: the current front entry (show-ahead).
REQ-012 The block SHALL have port level, output, ADDR_BITS+1: the current occupancy, 0..DEPTH.
REQ-013 The block SHALL have ports full, empty, almost_full and almost_empty, each an output of 1 bit: the status flags.

Function
REQ-014 The block SHALL accept a write when wr_en=1 and (level<DEPTH or rd_en=1); the block SHALL drop any other write.
REQ-015 The block SHALL accept a read when rd_en=1 and level>0; a read issued while empty SHALL have no effect, even with a simultaneous write (no fall-through).
REQ-016 A simultaneous accepted read and write while full SHALL pop the front and store wr_data, with level remaining DEPTH.
REQ-017 Each accepted write SHALL store wr_data at wr_ptr and increment wr_ptr modulo DEPTH; each accepted read SHALL increment rd_ptr modulo DEPTH.
REQ-018 Next level SHALL equal level + accepted_write - accepted_read, computed at ADDR_BITS+1 width with no wrap.
REQ-019 rd_data SHALL present mem[rd_ptr] combinationally; its value while empty SHALL be don't-care.
REQ-020 The flags SHALL be decoded from registered level only: full = (level==DEPTH); empty = (level==0); almost_full = (level>=AF_THRESH); almost_empty = (level<=AE_THRESH).
REQ-021 Flush SHALL set level, rd_ptr and wr_ptr to 0 on the next edge, SHALL take priority over rd_en and wr_en in the same cycle, and SHALL leave memory contents undefined.
REQ-022 All status outputs SHALL change exactly one cycle after the clock edge that accepts a read or write, with latency write-to-rd_data of 1 cycle when previously empty.

Reset
REQ-023 Asserting reset SHALL immediately, without waiting for a clock, force level=0, both pointers to 0, empty=1, almost_empty=1, full=0 and almost_full=0 (almost_full=1 only if AF_THRESH==0).
REQ-024 Reset SHALL NOT clear memory contents, and reset asserted mid-transfer SHALL discard any in-flight accept.
REQ-025 After reset deasserts, the first clock edge SHALL behave as a normal cycle.

Configuration
REQ-026 When macro FIFO_ERR_FLAGS_EN is defined, the block SHALL add outputs overflow and underflow, each 1 bit and sticky.
REQ-027 With the macro defined, overflow SHALL set on a dropped write and underflow SHALL set on rd_en while empty; both SHALL be cleared by reset or flush, and flush SHALL win over a same-cycle set.
REQ-028 Without the macro, the block SHALL omit those ports and logic, with all other behaviour identical.

Structure
REQ-029 A shared package fifo_pkg SHALL hold the default DATA_BITS and ADDR_BITS constants and a level-width helper function (ADDR_BITS+1).
REQ-030 Storage SHALL live in sub-module fifo_ram, a DEPTH x DATA_BITS array with a synchronous write port and an asynchronous read port, and SHALL not be reset.
REQ-031 Pointer, level, flag and error logic SHALL reside in fifo_level.
REQ-032 The design SHALL reject AF_THRESH>DEPTH or AE_THRESH>DEPTH at elaboration.

Verification
(All scenarios use DATA_BITS=8, ADDR_BITS=3.)
REQ-033 Scenario fill/drain: after reset, write 0x01..0x08 on 8 consecutive cycles -> level 8, full=1, almost_full=1 after the 7th write; then read 8 times -> rd_data 0x01..0x08 in order, empty=1.
REQ-034 Scenario full, read plus write: at level 8 with front 0x01, assert rd_en and wr_en with 0xAA -> level stays 8, front becomes 0x02, and 0xAA appears as the 8th read.
REQ-035 Scenario empty, read plus write: at level 0, assert rd_en and wr_en with 0x55 -> level 1, rd_data=0x55 next cycle, and underflow sets (macro defined).
REQ-036 Scenario overflow: at level 8, write 0x77 without rd_en -> level 8, 0x77 never read, overflow=1 until flush.
REQ-037 Scenario flush: at level 5, assert flush, wr_en and rd_en together -> next cycle level 0, empty=1 and error flags 0.
REQ-038 Scenario async reset: assert reset mid-clock at level 3 with wr_en high -> level 0 and empty=1 before the next edge; the write is lost.
